retire_grouper: RTL and testbench
=================================

# retire_grouper

Parametrised successor of the single-lane retire FSM in the CVA6 trace-encoder connector. It consumes up to NRET committed instructions per cycle from the connector FIFO and groups them into trace blocks. Each block carries a start address, a retired-halfword count, the size of the last instruction, and the special-instruction payload. The block drives the encoder through a registered valid/ready output with backpressure, and it closes a block early when the retire counter would overflow.

## Interface
- NRET, 2: commit lanes per cycle (≥1); lane 0 is oldest.
- IRETIRE_LEN, mure_pkg::IRETIRE_LEN: counter width (≥2); MAX = 2^IRETIRE_LEN−1 halfwords.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- entry_i  in  NRET × mure_pkg::fifo_entry_s  candidate instructions (valid, itype, pc, compressed, cause, tval, priv); valid lanes are contiguous from lane 0.
- accept_o  out  $clog2(NRET+1)  number of lanes consumed this cycle; the FIFO pops exactly this many.
- valid_o  out  1  output block available.
- ready_i  in  1  encoder takes the block when valid_o && ready_i.
- iaddr_o  out  mure_pkg::XLEN  pc of the first instruction in the block.
- iretire_o  out  IRETIRE_LEN  halfwords retired in the block, including the last instruction.
- ilastsize_o  out  1  last instruction was 32-bit (1) or compressed (0).
- itype_o  out  mure_pkg::ITYPE_LEN  itype of the closing instruction; 0 marks an overflow block.
- cause_o / tval_o / priv_o  out  CAUSE_LEN / XLEN / PRIV_LEN  payload of the closing instruction; 0 for overflow blocks.

## Operation
- States: IDLE (no open block) and COUNT (open block; iaddr_q, cnt_q and lastsize_q are live).
- inc(lane) = 1 if compressed, else 2. A special instruction has itype ≠ 0; exceptions are included.
- Lane scan, in order from lane 0, using a running count acc that starts at cnt_q (0 in IDLE). A valid lane L is handled as follows:
  - Overflow: if a block is open (or opened earlier this cycle) and acc+inc(L) > MAX:
    - emit an overflow block (itype 0, ilastsize = size of the last consumed instruction);
    - do not consume L and stop the scan;
    - the next state is IDLE.
  - Otherwise, consume L. If no block is open, latch iaddr = pc(L). Then acc += inc(L).
  - If L is special: emit a block with acc, !compressed(L) and L's payload, stop the scan, and go to IDLE.
  - If L is standard: continue to the next lane. At the end of the scan, go to COUNT with cnt_q = acc.
- At most one block is emitted per cycle. Lanes after an emitting lane are left for the next cycle.
- Backpressure: out_busy = valid_o && !ready_i.
  - While out_busy, the scan stops before any lane whose handling would emit a block.
  - Standard lanes that fit still accumulate.
- An invalid lane 0 gives accept_o = 0 and no state change.
- After accumulation, cnt_q ≤ MAX is always true, so the adder needs no wrap: compute at IRETIRE_LEN+1 bits and compare against MAX.

## Timing
- Reset (rst_i = 1 at an edge): state IDLE. valid_o, iaddr_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, cnt_q and lastsize_q are all 0. accept_o is 0 while rst_i is high.
- Reset mid-block discards the open count; nothing is emitted.
- accept_o is combinational from entry_i, the state and out_busy, with zero latency.
- A block emitted at edge N has valid_o high from N. The output holds stable until the cycle after valid_o && ready_i.
- valid_o && ready_i in the same cycle as a new emit loads the new block at the same edge. Throughput is one block per cycle.
- With no new emit, valid_o clears on the edge after the handshake.

## Structure
- Belong in mure_pkg: fifo_entry_s, state_e {IDLE, COUNT}, ITYPE_LEN, CAUSE_LEN, PRIV_LEN, XLEN and the IRETIRE_LEN default.
- Sub-module: none. The lane scan is an unrolled for-loop in a single always_comb, and the output register is one always_ff bank.

## Test plan
- Base case, NRET=2: lane0 standard, compressed, pc 0x100; lane1 branch (itype 4), 32-bit, pc 0x102. Response: accept_o = 2. Next cycle: valid_o = 1, iaddr 0x100, iretire 3, ilastsize 1, itype 4.
- Two specials in one cycle: lane0 exception (itype 1, cause 2, tval 0xdead) and lane1 special. Response: accept_o = 1 and one block (iretire 2, cause 2, tval 0xdead). Lane1 is emitted on the following cycle with iaddr = its pc.
- Overflow, IRETIRE_LEN=3: four 32-bit standard instructions. Cycle 1: accept 2, cnt 4. Cycle 2: accept 1, cnt 6. Cycle 3: lane0 needs 8 > 7, so accept 0 and emit an overflow block with iretire 6, itype 0, ilastsize 1. Cycle 4: a new block opens at the next instruction's pc.
- Backpressure: hold ready_i = 0 with a block pending and present standard + special lanes. Response: accept_o = 1 (the standard lane accumulates) and the output stays stable. On ready_i = 1, the special lane is accepted and the new block appears on the edge after the handshake.
- Reset mid-operation: rst_i = 1 for one cycle with cnt_q = 5 in COUNT. Response: all outputs 0 and state IDLE. The next block starts its iretire from 0.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared types and widths for the trace-encoder connector.
// Holds the FIFO entry layout handed over by the commit stage, the grouper
// state encoding, and the field widths used on the encoder interface.
package mure_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ITYPE_LEN   = 3;
    localparam int unsigned CAUSE_LEN   = 5;
    localparam int unsigned PRIV_LEN    = 2;
    localparam int unsigned IRETIRE_LEN = 14;

    typedef struct packed {
        logic                 valid;
        logic [ITYPE_LEN-1:0] itype;      // 0 = standard, anything else closes a block
        logic [XLEN-1:0]      pc;
        logic                 compressed; // 16-bit instruction
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } fifo_entry_s;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/retire_grouper.sv
// Groups up to NRET committed instructions per cycle into trace blocks.
//
// State table:
//   IDLE  | no open block; next valid lane starts a new block
//   COUNT | block open; iaddr_q, cnt_q and lastsize_q describe it
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   entry_i        NRET candidate instructions, lane 0 oldest, valid lanes contiguous
//   accept_o       number of lanes consumed this cycle (FIFO pop count)
//   valid_o/ready_i registered block handshake towards the encoder
//   iaddr_o        pc of first instruction in the block
//   iretire_o      halfwords retired in the block
//   ilastsize_o    last instruction was 32-bit
//   itype_o, cause_o, tval_o, priv_o  closing instruction payload (0 on overflow)
module retire_grouper
    import mure_pkg::*;
#(
    parameter int unsigned NRET        = 2,
    parameter int unsigned IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  fifo_entry_s [NRET-1:0]       entry_i,
    output logic [$clog2(NRET+1)-1:0]    accept_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [XLEN-1:0]              iaddr_o,
    output logic [IRETIRE_LEN-1:0]       iretire_o,
    output logic                         ilastsize_o,
    output logic [ITYPE_LEN-1:0]         itype_o,
    output logic [CAUSE_LEN-1:0]         cause_o,
    output logic [XLEN-1:0]              tval_o,
    output logic [PRIV_LEN-1:0]          priv_o
);

    localparam int unsigned AW = $clog2(NRET+1);
    localparam logic [IRETIRE_LEN:0] MAX = {1'b0, {IRETIRE_LEN{1'b1}}};

    state_e                 state_q, state_d;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
    logic                   lastsize_q, lastsize_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;

    logic                   valid_q;
    logic [XLEN-1:0]        oaddr_q;
    logic [IRETIRE_LEN-1:0] oretire_q;
    logic                   olastsize_q;
    logic [ITYPE_LEN-1:0]   itype_q;
    logic [CAUSE_LEN-1:0]   cause_q;
    logic [XLEN-1:0]        tval_q;
    logic [PRIV_LEN-1:0]    priv_q;

    logic                   out_busy;
    logic [IRETIRE_LEN:0]   acc, sum;
    logic                   open_blk, stop, emit, run_lastsize;
    logic [AW-1:0]          n_acc;
    logic [IRETIRE_LEN-1:0] e_retire;
    logic                   e_lastsize;
    logic [ITYPE_LEN-1:0]   e_itype;
    logic [CAUSE_LEN-1:0]   e_cause;
    logic [XLEN-1:0]        e_tval;
    logic [PRIV_LEN-1:0]    e_priv;

    assign out_busy = valid_q && !ready_i;

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lastsize_q <= 1'b0;
            iaddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lastsize_q <= lastsize_d;
            iaddr_q    <= iaddr_d;
        end
    end

    // next-state: unrolled lane scan
    always_comb begin
        open_blk     = (state_q == COUNT);
        acc          = open_blk ? {1'b0, cnt_q} : '0;
        sum          = '0;
        iaddr_d      = iaddr_q;
        run_lastsize = lastsize_q;
        stop         = 1'b0;
        emit         = 1'b0;
        n_acc        = '0;
        e_retire     = '0;
        e_lastsize   = 1'b0;
        e_itype      = '0;
        e_cause      = '0;
        e_tval       = '0;
        e_priv       = '0;

        for (int l = 0; l < NRET; l++) begin
            if (!stop) begin
                if (!entry_i[l].valid) begin
                    stop = 1'b1;
                end else begin
                    // inc = 1 for compressed, 2 otherwise
                    sum = acc + {{(IRETIRE_LEN-1){1'b0}},
                                 ~entry_i[l].compressed, entry_i[l].compressed};
                    if (open_blk && (sum > MAX)) begin
                        // lane does not fit: close the block without it
                        stop = 1'b1;
                        if (!out_busy) begin
                            emit       = 1'b1;
                            e_retire   = acc[IRETIRE_LEN-1:0];
                            e_lastsize = run_lastsize;
                        end
                    end else if ((entry_i[l].itype != '0) && out_busy) begin
                        // a special lane would need the output register
                        stop = 1'b1;
                    end else begin
                        n_acc = n_acc + AW'(1);
                        if (!open_blk) begin
                            iaddr_d  = entry_i[l].pc;
                            open_blk = 1'b1;
                        end
                        acc          = sum;
                        run_lastsize = !entry_i[l].compressed;
                        if (entry_i[l].itype != '0) begin
                            stop       = 1'b1;
                            emit       = 1'b1;
                            e_retire   = acc[IRETIRE_LEN-1:0];
                            e_lastsize = run_lastsize;
                            e_itype    = entry_i[l].itype;
                            e_cause    = entry_i[l].cause;
                            e_tval     = entry_i[l].tval;
                            e_priv     = entry_i[l].priv;
                        end
                    end
                end
            end
        end

        if (emit || !open_blk) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lastsize_d = 1'b0;
        end else begin
            state_d    = COUNT;
            cnt_d      = acc[IRETIRE_LEN-1:0];
            lastsize_d = run_lastsize;
        end
    end

    // outputs
    always_comb begin
        accept_o = rst_i ? '0 : n_acc;
    end

    // block register: loading a new block also retires the one just handed over
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            oaddr_q     <= '0;
            oretire_q   <= '0;
            olastsize_q <= 1'b0;
            itype_q     <= '0;
            cause_q     <= '0;
            tval_q      <= '0;
            priv_q      <= '0;
        end else if (emit) begin
            valid_q     <= 1'b1;
            oaddr_q     <= iaddr_d;
            oretire_q   <= e_retire;
            olastsize_q <= e_lastsize;
            itype_q     <= e_itype;
            cause_q     <= e_cause;
            tval_q      <= e_tval;
            priv_q      <= e_priv;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o     = valid_q;
    assign iaddr_o     = oaddr_q;
    assign iretire_o   = oretire_q;
    assign ilastsize_o = olastsize_q;
    assign itype_o     = itype_q;
    assign cause_o     = cause_q;
    assign tval_o      = tval_q;
    assign priv_o      = priv_q;

endmodule

// File: tb/tb_retire_grouper.sv
module tb_retire_grouper;
    import mure_pkg::*;

    localparam int NRET = 2;
    localparam int IRL  = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    fifo_entry_s [NRET-1:0] entry;
    logic [1:0]             accept;
    logic                   valid, ready;
    logic [XLEN-1:0]        iaddr;
    logic [IRL-1:0]         iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;

    retire_grouper #(.NRET(NRET), .IRETIRE_LEN(IRL)) dut (
        .clk_i(clk), .rst_i(rst), .entry_i(entry), .accept_o(accept),
        .valid_o(valid), .ready_i(ready), .iaddr_o(iaddr), .iretire_o(iretire),
        .ilastsize_o(ilastsize), .itype_o(itype), .cause_o(cause),
        .tval_o(tval), .priv_o(priv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]      addr;
        logic [IRL-1:0]       ret;
        logic                 ls;
        logic [ITYPE_LEN-1:0] it;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } blk_t;

    blk_t exp_q[$];
    blk_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fifo_entry_s ent(logic [ITYPE_LEN-1:0] it, logic [XLEN-1:0] pc,
                                        logic c, logic [CAUSE_LEN-1:0] ca, logic [XLEN-1:0] tv);
        fifo_entry_s e;
        e.valid = 1'b1; e.itype = it; e.pc = pc; e.compressed = c;
        e.cause = ca; e.tval = tv; e.priv = 2'd3;
        return e;
    endfunction

    function automatic blk_t mkb(logic [XLEN-1:0] a, logic [IRL-1:0] r, logic ls,
                                 logic [ITYPE_LEN-1:0] it, logic [CAUSE_LEN-1:0] ca,
                                 logic [XLEN-1:0] tv, logic [PRIV_LEN-1:0] pv);
        blk_t b;
        b.addr = a; b.ret = r; b.ls = ls; b.it = it; b.cause = ca; b.tval = tv; b.priv = pv;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // scoreboard: every handshake pops one expected block
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 64'(valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("blk_iaddr",    64'(iaddr),     64'(mon_e.addr));
                chk("blk_iretire",  64'(iretire),   64'(mon_e.ret));
                chk("blk_lastsize", 64'(ilastsize), 64'(mon_e.ls));
                chk("blk_itype",    64'(itype),     64'(mon_e.it));
                chk("blk_cause",    64'(cause),     64'(mon_e.cause));
                chk("blk_tval",     64'(tval),      64'(mon_e.tval));
                chk("blk_priv",     64'(priv),      64'(mon_e.priv));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        entry = '0;
        entry[0] = ent(0, 'h100, 1'b1, 0, 0);
        at_neg();
        chk("rst_accept", 64'(accept), 64'(0));
        step();
        chk("rst_valid",   64'(valid),   64'(0));
        chk("rst_iaddr",   64'(iaddr),   64'(0));
        chk("rst_iretire", 64'(iretire), 64'(0));
        chk("rst_itype",   64'(itype),   64'(0));
        rst   = 1'b0;
        entry = '0;
        step();

        // base case
        entry[0] = ent(0, 'h100, 1'b1, 0, 0);
        entry[1] = ent(4, 'h102, 1'b0, 0, 0);
        exp_q.push_back(mkb('h100, 3, 1'b1, 4, 0, 0, 3));
        at_neg();
        chk("base_accept", 64'(accept), 64'(2));
        step();
        entry = '0;
        chk("base_valid", 64'(valid), 64'(1));
        at_neg();
        step();
        chk("base_valid_clear", 64'(valid), 64'(0));

        // two specials in one cycle, emitted back to back
        entry[0] = ent(1, 'h200, 1'b0, 2, 'hdead);
        entry[1] = ent(3, 'h204, 1'b1, 0, 0);
        exp_q.push_back(mkb('h200, 2, 1'b1, 1, 2, 'hdead, 3));
        at_neg();
        chk("two_spec_accept0", 64'(accept), 64'(1));
        step();
        entry[0] = ent(3, 'h204, 1'b1, 0, 0);
        entry[1] = '0;
        exp_q.push_back(mkb('h204, 1, 1'b0, 3, 0, 0, 3));
        at_neg();
        chk("two_spec_accept1", 64'(accept), 64'(1));
        step();
        entry = '0;
        at_neg();
        step();

        // overflow with MAX = 7
        entry[0] = ent(0, 'h300, 1'b0, 0, 0);
        entry[1] = ent(0, 'h304, 1'b0, 0, 0);
        at_neg();
        chk("ovf_c1_accept", 64'(accept), 64'(2));
        step();
        entry[0] = ent(0, 'h308, 1'b0, 0, 0);
        entry[1] = '0;
        at_neg();
        chk("ovf_c2_accept", 64'(accept), 64'(1));
        step();
        entry[0] = ent(0, 'h30c, 1'b0, 0, 0);
        exp_q.push_back(mkb('h300, 6, 1'b1, 0, 0, 0, 0));
        at_neg();
        chk("ovf_c3_accept", 64'(accept), 64'(0));
        step();
        chk("ovf_valid", 64'(valid), 64'(1));
        at_neg();
        chk("ovf_reopen_accept", 64'(accept), 64'(1));
        step();
        entry[0] = ent(2, 'h310, 1'b1, 0, 0);
        exp_q.push_back(mkb('h30c, 3, 1'b0, 2, 0, 0, 3));
        at_neg();
        chk("ovf_close_accept", 64'(accept), 64'(1));
        step();
        entry = '0;
        at_neg();
        step();

        // backpressure
        ready    = 1'b0;
        entry[0] = ent(5, 'h400, 1'b0, 0, 0);
        exp_q.push_back(mkb('h400, 2, 1'b1, 5, 0, 0, 3));
        at_neg();
        chk("bp_first_accept", 64'(accept), 64'(1));
        step();
        entry[0] = ent(0, 'h402, 1'b1, 0, 0);
        entry[1] = ent(6, 'h404, 1'b0, 0, 0);
        at_neg();
        chk("bp_std_accept", 64'(accept), 64'(1));
        step();
        entry[0] = ent(6, 'h404, 1'b0, 0, 0);
        entry[1] = '0;
        at_neg();
        chk("bp_hold_accept", 64'(accept), 64'(0));
        chk("bp_stable_addr", 64'(iaddr), 64'('h400));
        chk("bp_stable_ret",  64'(iretire), 64'(2));
        step();
        at_neg();
        chk("bp_hold_accept2", 64'(accept), 64'(0));
        chk("bp_stable_itype", 64'(itype), 64'(5));
        chk("bp_stable_valid", 64'(valid), 64'(1));
        step();
        ready = 1'b1;
        exp_q.push_back(mkb('h402, 3, 1'b1, 6, 0, 0, 3));
        at_neg();
        chk("bp_release_accept", 64'(accept), 64'(1));
        step();
        entry = '0;
        chk("bp_new_valid", 64'(valid), 64'(1));
        at_neg();
        step();

        // reset mid-block with cnt = 5
        entry[0] = ent(0, 'h500, 1'b0, 0, 0);
        entry[1] = ent(0, 'h504, 1'b0, 0, 0);
        at_neg();
        chk("rm_c1_accept", 64'(accept), 64'(2));
        step();
        entry[0] = ent(0, 'h508, 1'b1, 0, 0);
        entry[1] = '0;
        at_neg();
        chk("rm_c2_accept", 64'(accept), 64'(1));
        step();
        rst      = 1'b1;
        entry[0] = ent(4, 'h600, 1'b1, 0, 0);
        at_neg();
        chk("rm_rst_accept", 64'(accept), 64'(0));
        step();
        chk("rm_valid",    64'(valid),     64'(0));
        chk("rm_iaddr",    64'(iaddr),     64'(0));
        chk("rm_iretire",  64'(iretire),   64'(0));
        chk("rm_itype",    64'(itype),     64'(0));
        chk("rm_lastsize", 64'(ilastsize), 64'(0));
        chk("rm_priv",     64'(priv),      64'(0));
        rst = 1'b0;
        exp_q.push_back(mkb('h600, 1, 1'b0, 4, 0, 0, 3));
        at_neg();
        chk("rm_after_accept", 64'(accept), 64'(1));
        step();
        entry = '0;
        chk("rm_after_valid", 64'(valid), 64'(1));

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        step();
        step();
        chk("final_idle", 64'(valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
